ftdi_rx_axis_fifo: RTL and testbench
====================================

Name: ftdi_rx_axis_fifo

Overview:
- Receive-side AXI-Stream buffer that sits directly downstream of the FT60x 245-FIFO driver's m_axis output, all in the usb_clk domain.
- The driver does not honour backpressure mid-burst. This block therefore absorbs every beat the driver presents and drives almost_full_axis back to it, so a new USB read burst starts only when enough headroom exists.
- It presents a first-word-fall-through (FWFT) AXI-Stream master to the user logic and reports overflow and occupancy status.

Parameters:
- TDATA_WIDTH, 32, data width in bits; must be a multiple of 8 (16 or 32 for FT600/FT601).
- DEPTH, 1024, storage depth in beats; power of 2, minimum 16.
- AF_MARGIN, 256, free beats still remaining when almost_full_axis asserts; must be at least the maximum driver burst plus 4.

Ports:
- usb_clk  in  1  FT60x interface clock; single clock for the whole block.
- rstn_usbclk  in  1  asynchronous active-low reset.
- s_axis_tdata  in  TDATA_WIDTH  beat data from the driver.
- s_axis_tkeep  in  TDATA_WIDTH/8  byte keep.
- s_axis_tstrb  in  TDATA_WIDTH/8  byte strobe; stored alongside tkeep.
- s_axis_tlast  in  1  last beat of a USB read burst.
- s_axis_tvalid  in  1  beat valid; not gated by s_axis_tready at the source.
- s_axis_tready  out  1  high when not full; advisory only.
- almost_full_axis  out  1  headroom warning to the driver.
- m_axis_tdata  out  TDATA_WIDTH  FWFT output data.
- m_axis_tkeep  out  TDATA_WIDTH/8  output keep.
- m_axis_tstrb  out  TDATA_WIDTH/8  output strobe.
- m_axis_tlast  out  1  output last.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  consumer ready.
- level  out  clog2(DEPTH)+1  beats held, including the output stage.
- pkt_count  out  16  complete packets (tlast beats) held; saturates at 65535.
- overflow  out  1  sticky; set on the first dropped beat.
- drop_count  out  16  dropped beats; saturates at 65535.
- clr_status  in  1  synchronous pulse; clears overflow and drop_count.

Behaviour:
- Reset, async on rstn_usbclk low: read and write pointers 0, level 0, pkt_count 0, m_axis_tvalid 0, m_axis_t* data fields 0, s_axis_tready 0, almost_full_axis 1, overflow 0, drop_count 0. On the first edge after release, s_axis_tready goes to 1 and almost_full_axis goes to 0. Reset asserted mid-stream discards all contents; no partial beat survives.
- Storage: dual-port RAM (write port and registered read port) plus one FWFT output register.
  - Entry layout is {tlast, tstrb, tkeep, tdata}.
- Write: a beat is accepted when s_axis_tvalid and not full.
  - full means level equals DEPTH, evaluated from the registered level at the start of the cycle.
  - A read in the same cycle does not rescue a write attempted while full; that write is dropped.
- Drop: each s_axis_tvalid beat while full increments drop_count (saturating) and sets overflow.
  - Beats with all-zero tkeep are still stored, never filtered.
  - clr_status in the same cycle as a drop: clear wins and the count restarts at 0 on the next edge.
- Read: an output handshake (m_axis_tvalid and m_axis_tready) pops the output register.
  - The output register refills from RAM with no bubble when further data is stored; sustained throughput is 1 beat per clock each way.
  - m_axis_tvalid and the m_axis data fields hold stable while tvalid is high and tready is low.
- Latency: a beat written into an empty FIFO at edge k gives m_axis_tvalid = 1 after edge k+2.
- level: +1 per accepted write, −1 per output handshake, net 0 when both occur. Updated at the clock edge; never exceeds DEPTH and never goes below 0.
- almost_full_axis: registered; equals (next level ≥ DEPTH − AF_MARGIN). It deasserts when level drops below the threshold.
- pkt_count: +1 on an accepted write with tlast, −1 on an output handshake with tlast, net 0 when both occur.
- Pointers: width clog2(DEPTH); wrap naturally from DEPTH−1 to 0.
- Empty with m_axis_tready high: no pop, m_axis_tvalid stays 0.
- Simultaneous write and read at level 1: the output register reloads with the new beat and no tvalid gap occurs once the RAM read completes.

Test Plan:
- Reset, then 8 beats (data 0x1..0x8, tkeep 0xF, tlast on beat 8) with m_axis_tready=1 → output identical in order, first tvalid 2 cycles after the first write, pkt_count peaks at 1 and returns to 0.
- m_axis_tready=0 with 1024 beats written (DEPTH 1024, AF_MARGIN 256) → almost_full_axis rises on the edge where level reaches 768; level 1024; s_axis_tready 0.
- At full, 5 more valid beats → drop_count 5, overflow 1; clr_status pulse → both 0; the stored 1024 beats read out intact.
- Continuous write and read for 3000 beats with random tready (50%) → no data loss; level never exceeds DEPTH; pointers wrap correctly.
- Stall mid-read (tready held low 10 cycles) → m_axis outputs stable throughout; resumed order is correct.
- Reset asserted mid-burst at level 37 → next edge shows level 0, pkt_count 0, m_axis_tvalid 0; a new burst after release passes normally.

Source files
------------

// File: rtl/ftdi_rx_axis_fifo.sv
// Receive-side AXI-Stream FIFO behind the FT60x 245-FIFO driver.
// Absorbs every driver beat, signals headroom via almost_full_axis, and presents an FWFT master.
module ftdi_rx_axis_fifo #(
    parameter int unsigned TDATA_WIDTH = 32,
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned AF_MARGIN   = 256
) (
    input  logic                         usb_clk,
    input  logic                         rstn_usbclk,
    input  logic [TDATA_WIDTH-1:0]       s_axis_tdata,
    input  logic [TDATA_WIDTH/8-1:0]     s_axis_tkeep,
    input  logic [TDATA_WIDTH/8-1:0]     s_axis_tstrb,
    input  logic                         s_axis_tlast,
    input  logic                         s_axis_tvalid,
    output logic                         s_axis_tready,
    output logic                         almost_full_axis,
    output logic [TDATA_WIDTH-1:0]       m_axis_tdata,
    output logic [TDATA_WIDTH/8-1:0]     m_axis_tkeep,
    output logic [TDATA_WIDTH/8-1:0]     m_axis_tstrb,
    output logic                         m_axis_tlast,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic [$clog2(DEPTH):0]       level,
    output logic [15:0]                  pkt_count,
    output logic                         overflow,
    output logic [15:0]                  drop_count,
    input  logic                         clr_status
);

    localparam int unsigned KW = TDATA_WIDTH / 8;
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned EW = TDATA_WIDTH + 2 * KW + 1;
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_AF   = LW'(DEPTH - AF_MARGIN);

    logic [EW-1:0]  mem [DEPTH];
    logic [EW-1:0]  rd_data;
    logic           rd_valid;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [LW-1:0]  ram_cnt;

    logic           full;
    logic           wr_en;
    logic           drop;
    logic           out_pop;
    logic           out_load;
    logic           rd_en;
    logic           pkt_inc;
    logic           pkt_dec;
    logic [LW-1:0]  level_nxt;
    logic [LW-1:0]  ram_cnt_nxt;
    logic [15:0]    pkt_nxt;
    logic [15:0]    drop_nxt;

    // Three-stage occupancy: RAM entries, RAM read register, FWFT output register.
    // level spans all three so full/headroom reflect every beat not yet handed off.
    always_comb begin
        full        = (level == LVL_FULL);
        wr_en       = s_axis_tvalid && !full;
        drop        = s_axis_tvalid && full;
        out_pop     = m_axis_tvalid && m_axis_tready;
        out_load    = rd_valid && (!m_axis_tvalid || out_pop);
        rd_en       = (ram_cnt != '0) && (!rd_valid || out_load);
        pkt_inc     = wr_en && s_axis_tlast;
        pkt_dec     = out_pop && m_axis_tlast;

        level_nxt = level;
        case ({wr_en, out_pop})
            2'b10:   level_nxt = level + LW'(1);
            2'b01:   level_nxt = level - LW'(1);
            default: level_nxt = level;
        endcase

        ram_cnt_nxt = ram_cnt;
        case ({wr_en, rd_en})
            2'b10:   ram_cnt_nxt = ram_cnt + LW'(1);
            2'b01:   ram_cnt_nxt = ram_cnt - LW'(1);
            default: ram_cnt_nxt = ram_cnt;
        endcase

        pkt_nxt = pkt_count;
        case ({pkt_inc, pkt_dec})
            2'b10:   if (pkt_count != '1) pkt_nxt = pkt_count + 16'd1;
            2'b01:   if (pkt_count != '0) pkt_nxt = pkt_count - 16'd1;
            default: pkt_nxt = pkt_count;
        endcase

        drop_nxt = drop_count;
        if (clr_status)
            drop_nxt = '0;
        else if (drop && drop_count != '1)
            drop_nxt = drop_count + 16'd1;
    end

    always_ff @(posedge usb_clk) begin
        if (wr_en)
            mem[wr_ptr] <= {s_axis_tlast, s_axis_tstrb, s_axis_tkeep, s_axis_tdata};
        if (rd_en)
            rd_data <= mem[rd_ptr];
    end

    always_ff @(posedge usb_clk or negedge rstn_usbclk) begin
        if (!rstn_usbclk) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            ram_cnt          <= '0;
            rd_valid         <= 1'b0;
            level            <= '0;
            pkt_count        <= '0;
            s_axis_tready    <= 1'b0;
            almost_full_axis <= 1'b1;
            overflow         <= 1'b0;
            drop_count       <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + AW'(1);
            if (rd_en)
                rd_ptr <= rd_ptr + AW'(1);
            ram_cnt          <= ram_cnt_nxt;
            rd_valid         <= rd_en ? 1'b1 : (out_load ? 1'b0 : rd_valid);
            level            <= level_nxt;
            pkt_count        <= pkt_nxt;
            s_axis_tready    <= (level_nxt != LVL_FULL);
            almost_full_axis <= (level_nxt >= LVL_AF);
            overflow         <= clr_status ? 1'b0 : (overflow | drop);
            drop_count       <= drop_nxt;
        end
    end

    always_ff @(posedge usb_clk or negedge rstn_usbclk) begin
        if (!rstn_usbclk) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tstrb  <= '0;
            m_axis_tlast  <= 1'b0;
        end else begin
            if (out_load) begin
                m_axis_tvalid <= 1'b1;
                {m_axis_tlast, m_axis_tstrb, m_axis_tkeep, m_axis_tdata} <= rd_data;
            end else if (out_pop) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ftdi_rx_axis_fifo.sv
// Self-checking bench for ftdi_rx_axis_fifo: scoreboard queue of accepted beats,
// reference counters for level / packets / drops, scenario tasks run in sequence.
module tb_ftdi_rx_axis_fifo;

    localparam int TW        = 32;
    localparam int KW        = TW / 8;
    localparam int DEPTH     = 1024;
    localparam int AF_MARGIN = 256;
    localparam int LW        = $clog2(DEPTH) + 1;
    localparam int EW        = TW + 2 * KW + 1;

    logic            usb_clk = 1'b0;
    logic            rstn_usbclk = 1'b0;
    logic [TW-1:0]   s_axis_tdata = '0;
    logic [KW-1:0]   s_axis_tkeep = '0;
    logic [KW-1:0]   s_axis_tstrb = '0;
    logic            s_axis_tlast = 1'b0;
    logic            s_axis_tvalid = 1'b0;
    logic            s_axis_tready;
    logic            almost_full_axis;
    logic [TW-1:0]   m_axis_tdata;
    logic [KW-1:0]   m_axis_tkeep;
    logic [KW-1:0]   m_axis_tstrb;
    logic            m_axis_tlast;
    logic            m_axis_tvalid;
    logic            m_axis_tready = 1'b0;
    logic [LW-1:0]   level;
    logic [15:0]     pkt_count;
    logic            overflow;
    logic [15:0]     drop_count;
    logic            clr_status = 1'b0;

    int errors = 0;
    int checks = 0;

    logic [EW-1:0] sb[$];
    int            m_level = 0;
    int            m_pkt   = 0;
    int            m_drop  = 0;
    logic          m_ovf   = 1'b0;
    logic          hs;
    logic [EW-1:0] got;
    logic [EW-1:0] exp_b;

    ftdi_rx_axis_fifo #(
        .TDATA_WIDTH (TW),
        .DEPTH       (DEPTH),
        .AF_MARGIN   (AF_MARGIN)
    ) dut (
        .usb_clk          (usb_clk),
        .rstn_usbclk      (rstn_usbclk),
        .s_axis_tdata     (s_axis_tdata),
        .s_axis_tkeep     (s_axis_tkeep),
        .s_axis_tstrb     (s_axis_tstrb),
        .s_axis_tlast     (s_axis_tlast),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tready    (s_axis_tready),
        .almost_full_axis (almost_full_axis),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tkeep     (m_axis_tkeep),
        .m_axis_tstrb     (m_axis_tstrb),
        .m_axis_tlast     (m_axis_tlast),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tready    (m_axis_tready),
        .level            (level),
        .pkt_count        (pkt_count),
        .overflow         (overflow),
        .drop_count       (drop_count),
        .clr_status       (clr_status)
    );

    always #5 usb_clk = ~usb_clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // Advance one clock: update the reference model from the inputs and outputs
    // seen just before the edge, then return at the following falling edge.
    task automatic tick();
        logic was_full;
        was_full = (m_level == DEPTH);
        hs = 1'b0;
        if (m_axis_tvalid && m_axis_tready) begin
            hs  = 1'b1;
            got = {m_axis_tlast, m_axis_tstrb, m_axis_tkeep, m_axis_tdata};
            if (sb.size() != 0) exp_b = sb.pop_front();
            else                exp_b = 'x;
            m_level--;
            if (exp_b[EW-1] === 1'b1 && m_pkt > 0) m_pkt--;
        end
        if (s_axis_tvalid) begin
            if (!was_full) begin
                sb.push_back({s_axis_tlast, s_axis_tstrb, s_axis_tkeep, s_axis_tdata});
                m_level++;
                if (s_axis_tlast && m_pkt < 65535) m_pkt++;
            end else begin
                if (m_drop < 65535) m_drop++;
                m_ovf = 1'b1;
            end
        end
        if (clr_status) begin
            m_drop = 0;
            m_ovf  = 1'b0;
        end
        @(posedge usb_clk);
        @(negedge usb_clk);
    endtask

    task automatic rand_beat(input logic [TW-1:0] d);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tkeep  = KW'($urandom_range(0, 15));
        s_axis_tstrb  = KW'($urandom_range(0, 15));
        s_axis_tlast  = ($urandom_range(0, 7) == 0);
    endtask

    task automatic test_reset();
        rstn_usbclk   = 1'b0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        repeat (3) @(negedge usb_clk);
        checks++;
        if ({level, pkt_count, m_axis_tvalid, m_axis_tdata} !== '0) begin
            errors++;
            $display("FAIL reset_counts level=%0d pkt=%0d tvalid=%b tdata=%h, required all 0",
                     level, pkt_count, m_axis_tvalid, m_axis_tdata);
        end
        checks++;
        if ({s_axis_tready, almost_full_axis, overflow, drop_count} !== {1'b0, 1'b1, 1'b0, 16'd0}) begin
            errors++;
            $display("FAIL reset_status tready=%b af=%b ovf=%b drop=%0d, required 0 1 0 0",
                     s_axis_tready, almost_full_axis, overflow, drop_count);
        end
        rstn_usbclk = 1'b1;
        @(posedge usb_clk);
        @(negedge usb_clk);
        checks++;
        if ({s_axis_tready, almost_full_axis} !== 2'b10) begin
            errors++;
            $display("FAIL release_flags tready=%b af=%b, required 1 0", s_axis_tready, almost_full_axis);
        end
    endtask

    task automatic test_basic();
        int first_v = -1;
        int peak    = 0;
        m_axis_tready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            if (i < 8) begin
                s_axis_tvalid = 1'b1;
                s_axis_tdata  = TW'(i + 1);
                s_axis_tkeep  = '1;
                s_axis_tstrb  = '1;
                s_axis_tlast  = (i == 7);
            end else begin
                s_axis_tvalid = 1'b0;
                s_axis_tlast  = 1'b0;
            end
            tick();
            if (m_axis_tvalid && first_v < 0) first_v = i;
            if (int'(pkt_count) > peak) peak = int'(pkt_count);
            if (hs) begin
                checks++;
                if (got !== exp_b) begin
                    errors++;
                    $display("FAIL basic_data got=%h required=%h", got, exp_b);
                end
            end
            checks++;
            if (level !== LW'(m_level) || pkt_count !== 16'(m_pkt)) begin
                errors++;
                $display("FAIL basic_level level=%0d pkt=%0d required %0d %0d", level, pkt_count, m_level, m_pkt);
            end
        end
        checks++;
        if (first_v != 2) begin
            errors++;
            $display("FAIL basic_latency first tvalid after tick %0d, required 2", first_v);
        end
        checks++;
        if (peak != 1) begin
            errors++;
            $display("FAIL basic_pkt_peak got=%0d required=1", peak);
        end
        checks++;
        if (sb.size() != 0 || m_axis_tvalid !== 1'b0 || level !== '0) begin
            errors++;
            $display("FAIL basic_empty left=%0d tvalid=%b level=%0d, required 0 0 0", sb.size(), m_axis_tvalid, level);
        end
    endtask

    task automatic test_fill();
        m_axis_tready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            rand_beat(TW'($urandom));
            tick();
            checks++;
            if (level !== LW'(m_level) || almost_full_axis !== (m_level >= DEPTH - AF_MARGIN)
                || s_axis_tready !== (m_level != DEPTH)) begin
                errors++;
                $display("FAIL fill_flags i=%0d level=%0d af=%b tready=%b, required level %0d af %b tready %b",
                         i, level, almost_full_axis, s_axis_tready, m_level,
                         m_level >= DEPTH - AF_MARGIN, m_level != DEPTH);
            end
        end
        checks++;
        if (level !== LW'(DEPTH) || s_axis_tready !== 1'b0 || almost_full_axis !== 1'b1) begin
            errors++;
            $display("FAIL fill_full level=%0d tready=%b af=%b, required 1024 0 1", level, s_axis_tready, almost_full_axis);
        end
    endtask

    task automatic test_overflow();
        int n_out = 0;
        for (int i = 0; i < 5; i++) begin
            rand_beat(32'hDEAD_0000 + TW'(i));
            tick();
        end
        checks++;
        if (drop_count !== 16'd5 || overflow !== 1'b1 || level !== LW'(DEPTH)) begin
            errors++;
            $display("FAIL ovf_count drop=%0d ovf=%b level=%0d, required 5 1 1024", drop_count, overflow, level);
        end
        rand_beat(32'hDEAD_BEEF);
        clr_status = 1'b1;
        tick();
        clr_status    = 1'b0;
        s_axis_tvalid = 1'b0;
        checks++;
        if (drop_count !== 16'(m_drop) || overflow !== m_ovf || drop_count !== 16'd0) begin
            errors++;
            $display("FAIL ovf_clear drop=%0d ovf=%b, required 0 0", drop_count, overflow);
        end
        m_axis_tready = 1'b1;
        for (int n = 0; n < DEPTH + 20 && (sb.size() != 0 || m_axis_tvalid); n++) begin
            tick();
            if (hs) begin
                n_out++;
                checks++;
                if (got !== exp_b) begin
                    errors++;
                    $display("FAIL ovf_drain_data n=%0d got=%h required=%h", n_out, got, exp_b);
                end
            end
            checks++;
            if (level !== LW'(m_level) || almost_full_axis !== (m_level >= DEPTH - AF_MARGIN)) begin
                errors++;
                $display("FAIL ovf_drain_level level=%0d af=%b required %0d", level, almost_full_axis, m_level);
            end
        end
        checks++;
        if (n_out != DEPTH || sb.size() != 0) begin
            errors++;
            $display("FAIL ovf_drain_count read=%0d left=%0d, required %0d 0", n_out, sb.size(), DEPTH);
        end
    endtask

    task automatic test_stream();
        int accepted = 0;
        int cyc      = 0;
        while (accepted < 3000 && cyc < 20000) begin
            if ($urandom_range(0, 99) < 45) rand_beat(TW'($urandom));
            else s_axis_tvalid = 1'b0;
            m_axis_tready = ($urandom_range(0, 1) == 1);
            if (s_axis_tvalid && m_level != DEPTH) accepted++;
            tick();
            cyc++;
            if (hs) begin
                checks++;
                if (got !== exp_b) begin
                    errors++;
                    $display("FAIL stream_data cyc=%0d got=%h required=%h", cyc, got, exp_b);
                end
            end
            checks++;
            if (level !== LW'(m_level) || level > LW'(DEPTH) || pkt_count !== 16'(m_pkt)) begin
                errors++;
                $display("FAIL stream_level cyc=%0d level=%0d pkt=%0d required %0d %0d",
                         cyc, level, pkt_count, m_level, m_pkt);
            end
        end
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        for (int n = 0; n < DEPTH + 20 && (sb.size() != 0 || m_axis_tvalid); n++) begin
            tick();
            if (hs) begin
                checks++;
                if (got !== exp_b) begin
                    errors++;
                    $display("FAIL stream_drain got=%h required=%h", got, exp_b);
                end
            end
        end
        checks++;
        if (accepted < 3000 || sb.size() != 0 || level !== '0 || drop_count !== 16'(m_drop)) begin
            errors++;
            $display("FAIL stream_end accepted=%0d left=%0d level=%0d drop=%0d, required 3000 0 0 %0d",
                     accepted, sb.size(), level, drop_count, m_drop);
        end
    endtask

    task automatic test_stall();
        logic [EW:0] snap;
        m_axis_tready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            rand_beat(32'h5A00_0000 + TW'(i));
            tick();
        end
        s_axis_tvalid = 1'b0;
        repeat (2) tick();
        m_axis_tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (!hs || got !== exp_b) begin
                errors++;
                $display("FAIL stall_pre hs=%b got=%h required=%h", hs, got, exp_b);
            end
        end
        m_axis_tready = 1'b0;
        snap = {m_axis_tvalid, m_axis_tlast, m_axis_tstrb, m_axis_tkeep, m_axis_tdata};
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if ({m_axis_tvalid, m_axis_tlast, m_axis_tstrb, m_axis_tkeep, m_axis_tdata} !== snap
                || snap[EW] !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold i=%0d got=%h required=%h",
                         i, {m_axis_tvalid, m_axis_tlast, m_axis_tstrb, m_axis_tkeep, m_axis_tdata}, snap);
            end
        end
        m_axis_tready = 1'b1;
        for (int n = 0; n < 40 && (sb.size() != 0 || m_axis_tvalid); n++) begin
            tick();
            if (hs) begin
                checks++;
                if (got !== exp_b) begin
                    errors++;
                    $display("FAIL stall_resume got=%h required=%h", got, exp_b);
                end
            end
        end
        checks++;
        if (sb.size() != 0 || level !== '0) begin
            errors++;
            $display("FAIL stall_end left=%0d level=%0d, required 0 0", sb.size(), level);
        end
    endtask

    task automatic test_mid_reset();
        m_axis_tready = 1'b0;
        for (int i = 0; i < 37; i++) begin
            rand_beat(32'h3700_0000 + TW'(i));
            s_axis_tlast = (i % 8 == 7);
            tick();
        end
        checks++;
        if (level !== LW'(37) || pkt_count !== 16'd4) begin
            errors++;
            $display("FAIL midrst_pre level=%0d pkt=%0d, required 37 4", level, pkt_count);
        end
        rstn_usbclk = 1'b0;
        @(posedge usb_clk);
        @(negedge usb_clk);
        checks++;
        if (level !== '0 || pkt_count !== '0 || m_axis_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_clear level=%0d pkt=%0d tvalid=%b, required 0 0 0", level, pkt_count, m_axis_tvalid);
        end
        sb.delete();
        m_level = 0;
        m_pkt   = 0;
        m_drop  = 0;
        m_ovf   = 1'b0;
        s_axis_tvalid = 1'b0;
        rstn_usbclk   = 1'b1;
        tick();
        m_axis_tready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (i < 8) begin
                rand_beat(32'hA500_0000 + TW'(i));
                s_axis_tlast = (i == 7);
            end else begin
                s_axis_tvalid = 1'b0;
            end
            tick();
            if (hs) begin
                checks++;
                if (got !== exp_b) begin
                    errors++;
                    $display("FAIL midrst_burst got=%h required=%h", got, exp_b);
                end
            end
        end
        checks++;
        if (sb.size() != 0 || level !== '0 || pkt_count !== '0) begin
            errors++;
            $display("FAIL midrst_end left=%0d level=%0d pkt=%0d, required 0 0 0", sb.size(), level, pkt_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill();
        test_overflow();
        test_stream();
        test_stall();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
